// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI register bank: default widths,
// the ID register, the software register map, and arbiter enums.
package spi_regs_pkg;

  localparam int unsigned ADDR_BITS_DEF = 7;
  localparam int unsigned DATA_BITS_DEF = 8;
  localparam logic [6:0]  ID_ADDR_DEF   = 7'h7F;
  localparam logic [7:0]  ID_VALUE_DEF  = 8'hA5;

  // register map shared by the datapath and the SPI software map
  localparam logic [6:0] REG_CTRL      = 7'h00;
  localparam logic [6:0] REG_STATUS    = 7'h01;
  localparam logic [6:0] REG_GAIN      = 7'h10;
  localparam logic [6:0] REG_OFFSET    = 7'h11;
  localparam logic [6:0] REG_FILT_SEL  = 7'h12;
  localparam logic [6:0] REG_DSP_BASE  = 7'h20;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} arb_state_e;
  typedef enum logic [1:0] {K_RAM, K_ID, K_ZERO} addr_kind_e;

endpackage

// File: rtl/reg_ram.sv
// Single-port synchronous register RAM: write-first, registered read.
module reg_ram #(
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 128
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else if (32'(addr) < DEPTH) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Register bank shared between the SPI slave (always wins) and one internal
// req/ack requester; clears the RAM after reset and broadcasts SPI writes.
module spi_reg_arbiter
  import spi_regs_pkg::*;
#(
  parameter int unsigned          ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned          DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned          NUM_REGS  = 128,
  parameter logic [DATA_BITS-1:0] ID_VALUE  = DATA_BITS'(ID_VALUE_DEF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_read_stb,
  input  logic                 spi_write_stb,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [DATA_BITS-1:0] spi_write_data,
  output logic [DATA_BITS-1:0] spi_read_data,
  input  logic                 int_req,
  input  logic                 int_we,
  input  logic [ADDR_BITS-1:0] int_addr,
  input  logic [DATA_BITS-1:0] int_wdata,
  output logic                 int_ack,
  output logic [DATA_BITS-1:0] int_rdata,
  output logic                 cfg_stb,
  output logic [ADDR_BITS-1:0] cfg_addr,
  output logic [DATA_BITS-1:0] cfg_data
);

  localparam logic [ADDR_BITS-1:0] ID_ADDR = '1;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } ram_req_t;

  function automatic addr_kind_e decode(input logic [ADDR_BITS-1:0] a);
    if (a == ID_ADDR)          return K_ID;
    else if (32'(a) < NUM_REGS) return K_RAM;
    else                       return K_ZERO;
  endfunction

  function automatic logic [DATA_BITS-1:0] kind_data(input addr_kind_e k,
                                                     input logic [DATA_BITS-1:0] rd);
    case (k)
      K_RAM:   return rd;
      K_ID:    return ID_VALUE;
      default: return '0;
    endcase
  endfunction

  arb_state_e           state;
  logic                 clearing;
  logic [ADDR_BITS-1:0] clr_cnt;
  addr_kind_e           int_kind;
  logic                 spi_rd_vld;
  addr_kind_e           spi_rd_kind;
  logic [DATA_BITS-1:0] spi_rd_hold;
  logic [DATA_BITS-1:0] ram_rdata;
  ram_req_t             ram_req;
  logic                 int_grant;
  logic                 spi_commit;
  logic                 spi_rd_take;

  // write wins over a simultaneous read strobe
  assign spi_rd_take = spi_read_stb && !spi_write_stb;

  // port grant: clear counter, then SPI, then an internal request from IDLE
  always_comb begin
    ram_req    = '{we: 1'b0, addr: spi_addr, wdata: spi_write_data};
    int_grant  = 1'b0;
    spi_commit = 1'b0;
    if (clearing) begin
      ram_req = '{we: 1'b1, addr: clr_cnt, wdata: '0};
    end else if (spi_write_stb) begin
      spi_commit = (decode(spi_addr) == K_RAM);
      ram_req.we = spi_commit;
    end else if (spi_read_stb) begin
      ram_req.we = 1'b0;
    end else if (state == IDLE && int_req) begin
      int_grant = 1'b1;
      ram_req   = '{we: int_we && (decode(int_addr) == K_RAM), addr: int_addr,
                    wdata: int_wdata};
    end
  end

  reg_ram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .DEPTH(NUM_REGS)) u_ram (
    .clk   (clk),
    .we    (ram_req.we),
    .addr  (ram_req.addr),
    .wdata (ram_req.wdata),
    .rdata (ram_rdata)
  );

  // RAM output is presented directly in the cycle after a read, then held
  assign spi_read_data = spi_rd_vld ? kind_data(spi_rd_kind, ram_rdata) : spi_rd_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      clearing    <= 1'b1;
      clr_cnt     <= '0;
      int_kind    <= K_ZERO;
      int_ack     <= 1'b0;
      int_rdata   <= '0;
      cfg_stb     <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      spi_rd_vld  <= 1'b0;
      spi_rd_kind <= K_ZERO;
      spi_rd_hold <= '0;
    end else begin
      if (clearing) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == ADDR_BITS'(NUM_REGS - 1)) clearing <= 1'b0;
      end

      cfg_stb <= spi_commit;
      if (spi_commit) begin
        cfg_addr <= spi_addr;
        cfg_data <= spi_write_data;
      end

      spi_rd_vld <= spi_rd_take;
      if (spi_rd_take) spi_rd_kind <= clearing ? K_ZERO : decode(spi_addr);
      if (spi_rd_vld)  spi_rd_hold <= spi_read_data;

      // the internal read is captured in ISSUE, before any SPI access reuses the port
      int_ack <= 1'b0;
      case (state)
        IDLE: if (int_grant) begin
          state    <= ISSUE;
          int_kind <= decode(int_addr);
        end
        ISSUE: begin
          state     <= ACK;
          int_ack   <= 1'b1;
          int_rdata <= kind_data(int_kind, ram_rdata);
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
